render_rect_datapath: RTL and testbench
=======================================

# render_rect_datapath

Drawing datapath for the rectangle renderer. It sits directly downstream of the rectangle control FSM and consumes its `ld_x`, `ld_y` and `start_count` strobes. It latches an X/Y origin from the switch data bus, then emits one pixel per cycle (`x_out`, `y_out`, `colour_out`, `plot`) covering a fixed BOX_W×BOX_H box for the VGA adapter. It flags completion with a one-cycle `done` pulse.

## Interface
- X_W, 8: width of x coordinate and of `x_out`
- Y_W, 7: width of y coordinate and of `y_out`
- COLOUR_W, 3: colour width
- BOX_W, 4: box width in pixels (≥1)
- BOX_H, 4: box height in pixels (≥1)
- SCREEN_W, 160: visible columns (used only with clipping)
- SCREEN_H, 120: visible rows (used only with clipping)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ld_x  in  1  load `x_reg` from `data_in[X_W-1:0]`
- ld_y  in  1  load `y_reg` from `data_in[Y_W-1:0]`
- start_count  in  1  start drawing (one-cycle strobe from control)
- data_in  in  X_W  coordinate source (switches)
- colour_in  in  COLOUR_W  fill colour, sampled at start
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour_out  out  COLOUR_W  pixel colour
- plot  out  1  pixel valid, write enable to the VGA adapter
- busy  out  1  high while a box is in progress
- done  out  1  one-cycle pulse after the last pixel

## Operation
- Registers: `x_reg`, `y_reg` (load regs); `base_x`, `base_y`, `col_reg` (snapshot); `cx` (0..BOX_W-1) and `cy` (0..BOX_H-1) counters; 2-bit state.
- `ld_x`/`ld_y` update `x_reg`/`y_reg` in any state. Both asserted in the same cycle: both load.
- FSM states:
  - IDLE: on `start_count`, snapshot `base_x←x_reg`, `base_y←y_reg`, `col_reg←colour_in`, clear `cx`/`cy`, then go to DRAW.
  - DRAW: emit pixel (`base_x+cx`, `base_y+cy`).
    - `cx` increments each cycle.
    - At `cx==BOX_W-1`, `cx` wraps to 0 and `cy` increments.
    - At `cx==BOX_W-1 && cy==BOX_H-1`, go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Pixel order is row-major, column fastest.
- `start_count` in DRAW or DONE is ignored; no queuing.
- Loads during DRAW do not affect the box in progress, because drawing uses the snapshot.
- Arithmetic: `x_out = (base_x+cx) mod 2^X_W` and `y_out = (base_y+cy) mod 2^Y_W`. Sums wrap silently when clipping is not compiled in.
- `busy` = state is DRAW or DONE.

## Timing
- Reset (async, active-high), all cleared:
  - state=IDLE
  - `x_reg`, `y_reg`, `base_x`, `base_y`, `col_reg`, `cx`, `cy` = 0
  - `x_out`=0, `y_out`=0, `colour_out`=0
  - `plot`=0, `busy`=0, `done`=0
- Outputs are registered.
- `start_count` sampled high at edge N:
  - First pixel is valid (`plot`=1) in cycle N+1.
  - Last pixel is in cycle N+BOX_W·BOX_H.
  - `done`=1 in cycle N+BOX_W·BOX_H+1.
  - IDLE again at N+BOX_W·BOX_H+2.
- Back-to-back: a new `start_count` is accepted in the first IDLE cycle after DONE.
- `plot` is high for exactly BOX_W·BOX_H cycles per box, fewer if clipping removes pixels.
- `colour_out` is constant for the whole box.
- Reset asserted mid-DRAW:
  - `plot`, `busy` and `done` drop immediately (async).
  - No `done` is issued for the aborted box.
  - After release, the block waits in IDLE for a new start.
- BOX_W=BOX_H=1: one `plot` cycle, then `done`.

## Configuration
- Macro: `RENDER_RECT_CLIP_EN`.
- Defined:
  - A pixel with unwrapped `base_x+cx ≥ SCREEN_W` or `base_y+cy ≥ SCREEN_H` has `plot`=0 for that cycle.
  - Traversal, cycle count and `done` timing are unchanged.
- Undefined:
  - No comparison is made; coordinates wrap mod 2^X_W / 2^Y_W and every cycle in DRAW plots.

## Test plan
- Reset, then `ld_x` with `data_in`=10 and `ld_y` with `data_in`=20; start with `colour_in`=3'b101 → 16 `plot` cycles.
  - Pixels (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23), all with `colour_out`=5.
  - `done` pulses exactly 1 cycle after (13,23).
- During DRAW: `ld_x` with `data_in`=50, and a second `start_count` → current box is unchanged and the extra start is ignored.
  - After `done`, a new start draws from x=50.
- Assert reset after the 5th pixel → `plot`/`busy` drop at once and no `done` appears.
  - A restart after release draws all 16 pixels.
- Without the macro, origin (254,126) with X_W=8, Y_W=7 → x sequence 254,255,0,1 and y sequence 126,127,0,1 (wrap).
- With `RENDER_RECT_CLIP_EN`, origin (158,118) → `plot`=1 only for the 4 pixels x∈{158,159}, y∈{118,119}.
  - `done` still arrives at N+17.
- BOX_W=BOX_H=1, origin (0,0) → single `plot` at N+1, `done` at N+2, `busy` low at N+3.

Source files
------------

// File: rtl/render_rect_datapath.sv
// render_rect_datapath
//   Drawing datapath for the rectangle renderer. Latches an X/Y origin from
//   the switch bus, then, on a start strobe, emits one pixel per cycle
//   covering a BOX_W x BOX_H box in row-major order (column fastest),
//   followed by a one-cycle done pulse.
//
//   Optional feature macro: RENDER_RECT_CLIP_EN
//     defined   : pixels whose unwrapped coordinate falls outside
//                 SCREEN_W x SCREEN_H are traversed but not plotted
//     undefined : coordinates wrap mod 2^X_W / 2^Y_W and every pixel plots
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-high reset
//   ld_x, ld_y   load x_reg / y_reg from data_in (any state)
//   start_count  start strobe, honoured only when idle
//   data_in      coordinate source
//   colour_in    fill colour, sampled at start
//   x_out, y_out pixel coordinate (registered)
//   colour_out   pixel colour (registered, constant over a box)
//   plot         pixel write enable
//   busy         box in progress (drawing or done cycle)
//   done         one-cycle pulse after the last pixel
module render_rect_datapath #(
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned COLOUR_W = 3,
   parameter int unsigned BOX_W    = 4,
   parameter int unsigned BOX_H    = 4,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ld_x,
   input  logic                ld_y,
   input  logic                start_count,
   input  logic [X_W-1:0]      data_in,
   input  logic [COLOUR_W-1:0] colour_in,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
   localparam int unsigned CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
   localparam logic [CX_W-1:0] CX_LAST = CX_W'(BOX_W - 1);
   localparam logic [CY_W-1:0] CY_LAST = CY_W'(BOX_H - 1);

   // Elaboration-time sanity on geometry parameters.
   if (BOX_W < 1 || BOX_H < 1) begin : g_bad_box
      $error("render_rect_datapath: BOX_W and BOX_H must be at least 1");
   end
   if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
      $error("render_rect_datapath: SCREEN_W and SCREEN_H must be at least 1");
   end
   if (Y_W > X_W) begin : g_bad_y_w
      $error("render_rect_datapath: Y_W must not exceed X_W");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [X_W-1:0]       x_reg, base_x, base_x_next;
   logic [Y_W-1:0]       y_reg, base_y, base_y_next;
   logic [COLOUR_W-1:0]  col_reg, col_next;
   logic [CX_W-1:0]      cx, cx_next;
   logic [CY_W-1:0]      cy, cy_next;

   logic [X_W-1:0]       x_next;
   logic [Y_W-1:0]       y_next;
   logic                 plot_next, busy_next, done_next;

   // Pixel to be presented in the next cycle: its base and offsets.
   logic                 pix_en;
   logic [X_W-1:0]       pix_bx;
   logic [Y_W-1:0]       pix_by;
   logic [CX_W-1:0]      pix_cx;
   logic [CY_W-1:0]      pix_cy;
   logic                 in_bounds;

`ifdef RENDER_RECT_CLIP_EN
   logic [31:0]          sum_x, sum_y;
`else
   logic [X_W-1:0]       sum_x;
   logic [Y_W-1:0]       sum_y;
`endif

   // Next-state and next-output logic. Outputs are registered, so the
   // pixel computed here is the one visible in the following cycle.
   always_comb begin
      state_next  = state;
      base_x_next = base_x;
      base_y_next = base_y;
      col_next    = col_reg;
      cx_next     = cx;
      cy_next     = cy;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      pix_en      = 1'b0;
      pix_bx      = base_x;
      pix_by      = base_y;
      pix_cx      = cx;
      pix_cy      = cy;

      unique case (state)
         S_IDLE: begin
            if (start_count) begin
               state_next  = S_DRAW;
               base_x_next = x_reg;
               base_y_next = y_reg;
               col_next    = colour_in;
               cx_next     = '0;
               cy_next     = '0;
               busy_next   = 1'b1;
               // First pixel goes straight from the load registers.
               pix_en      = 1'b1;
               pix_bx      = x_reg;
               pix_by      = y_reg;
               pix_cx      = '0;
               pix_cy      = '0;
            end
         end
         S_DRAW: begin
            busy_next = 1'b1;
            if (cx == CX_LAST) begin
               cx_next = '0;
               if (cy == CY_LAST) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
               end else begin
                  cy_next = cy + CY_W'(1);
                  pix_en  = 1'b1;
               end
            end else begin
               cx_next = cx + CX_W'(1);
               pix_en  = 1'b1;
            end
            pix_cx = cx_next;
            pix_cy = cy_next;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

`ifdef RENDER_RECT_CLIP_EN
      // Unwrapped sums so off-screen pixels are detected before truncation.
      sum_x     = 32'(pix_bx) + 32'(pix_cx);
      sum_y     = 32'(pix_by) + 32'(pix_cy);
      in_bounds = (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
      x_next    = pix_en ? sum_x[X_W-1:0] : x_out;
      y_next    = pix_en ? sum_y[Y_W-1:0] : y_out;
`else
      sum_x     = pix_bx + X_W'(pix_cx);
      sum_y     = pix_by + Y_W'(pix_cy);
      in_bounds = 1'b1;
      x_next    = pix_en ? sum_x : x_out;
      y_next    = pix_en ? sum_y : y_out;
`endif
      plot_next = pix_en && in_bounds;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         x_reg      <= '0;
         y_reg      <= '0;
         base_x     <= '0;
         base_y     <= '0;
         col_reg    <= '0;
         cx         <= '0;
         cy         <= '0;
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         if (ld_x) x_reg <= data_in;
         if (ld_y) y_reg <= data_in[Y_W-1:0];
         base_x     <= base_x_next;
         base_y     <= base_y_next;
         col_reg    <= col_next;
         cx         <= cx_next;
         cy         <= cy_next;
         x_out      <= x_next;
         y_out      <= y_next;
         colour_out <= col_next;
         plot       <= plot_next;
         busy       <= busy_next;
         done       <= done_next;
      end
   end

endmodule

// File: tb/tb_render_rect_datapath.sv
module tb_render_rect_datapath;

   localparam int unsigned XW = 8;
   localparam int unsigned YW = 7;
   localparam int unsigned CW = 3;
   localparam int unsigned BW = 4;
   localparam int unsigned BH = 4;
   localparam int unsigned SW = 160;
   localparam int unsigned SH = 120;
   localparam int          WH = BW * BH;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ld_x = 1'b0, ld_y = 1'b0, start_count = 1'b0;
   logic [XW-1:0] data_in = '0;
   logic [CW-1:0] colour_in = '0;
   logic [XW-1:0] x_out;
   logic [YW-1:0] y_out;
   logic [CW-1:0] colour_out;
   logic          plot, busy, done;

   logic          start1 = 1'b0;
   logic [XW-1:0] x1;
   logic [YW-1:0] y1;
   logic [CW-1:0] c1;
   logic          plot1, busy1, done1;

   render_rect_datapath #(.X_W(XW), .Y_W(YW), .COLOUR_W(CW), .BOX_W(BW), .BOX_H(BH),
                          .SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .clk(clk), .reset(reset), .ld_x(ld_x), .ld_y(ld_y), .start_count(start_count),
      .data_in(data_in), .colour_in(colour_in), .x_out(x_out), .y_out(y_out),
      .colour_out(colour_out), .plot(plot), .busy(busy), .done(done));

   render_rect_datapath #(.X_W(XW), .Y_W(YW), .COLOUR_W(CW), .BOX_W(1), .BOX_H(1),
                          .SCREEN_W(SW), .SCREEN_H(SH)) dut1 (
      .clk(clk), .reset(reset), .ld_x(1'b0), .ld_y(1'b0), .start_count(start1),
      .data_in('0), .colour_in(3'd7), .x_out(x1), .y_out(y1),
      .colour_out(c1), .plot(plot1), .busy(busy1), .done(done1));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: origin registers and the accepted box, indexed by
   // the number of rising edges since the box's start was sampled.
   int unsigned m_x = 0, m_y = 0, m_bx = 0, m_by = 0, m_bc = 0;
   logic        m_have = 1'b0;
   int          eidx = 0, m_sedge = 0;

   function automatic bit m_busy_now();
      int d;
      d = eidx - m_sedge;
      return m_have && d >= 0 && d <= WH;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_x    <= 0;
            m_y    <= 0;
            m_have <= 1'b0;
         end else begin
            eidx <= eidx + 1;
            if (start_count && !m_busy_now()) begin
               m_have  <= 1'b1;
               m_sedge <= eidx + 1;
               m_bx    <= m_x;
               m_by    <= m_y;
               m_bc    <= int'(colour_in);
            end
            if (ld_x) m_x <= int'(data_in);
            if (ld_y) m_y <= int'(data_in) % 128;
         end
      end
   end

   // Observation log for the hand-computed pins.
   int unsigned xs[$], ys[$];
   int          ncyc = 0, last_plot_cyc = -1, done_cyc = -1, done_cnt = 0;
   bit          chk_en = 1'b0;

   initial begin : compare_proc
      int d, k;
      bit act, e_pix, e_plot;
      int unsigned ex, ey, ux, uy;
      forever begin
         @(negedge clk);
         if (!reset && chk_en) begin
            ncyc++;
            d      = eidx - m_sedge;
            act    = m_have && d >= 0 && d <= WH;
            e_pix  = act && d < WH;
            k      = e_pix ? d : 0;
            ux     = m_bx + k % BW;
            uy     = m_by + k / BW;
            ex     = ux % 256;
            ey     = uy % 128;
`ifdef RENDER_RECT_CLIP_EN
            e_plot = e_pix && ux < SW && uy < SH;
`else
            e_plot = e_pix;
`endif
            chk("plot", 32'(plot), 32'(e_plot));
            chk("busy", 32'(busy), 32'(act));
            chk("done", 32'(done), 32'(act && d == WH));
            if (e_plot) begin
               chk("x_out", 32'(x_out), ex);
               chk("y_out", 32'(y_out), ey);
               chk("colour_out", 32'(colour_out), m_bc);
            end
            if (plot === 1'b1) begin
               xs.push_back(int'(x_out));
               ys.push_back(int'(y_out));
               last_plot_cyc = ncyc;
            end
            if (done === 1'b1) begin
               done_cyc = ncyc;
               done_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input int unsigned x, input int unsigned y);
      tick(); ld_x = 1'b1; data_in = XW'(x);
      tick(); ld_x = 1'b0; ld_y = 1'b1; data_in = XW'(y);
      tick(); ld_y = 1'b0;
   endtask

   // Returns the cycle number of the negedge just before the sampling edge;
   // the first pixel is expected at s+1 and done at s+WH+1.
   task automatic start(input int unsigned col, output int s);
      tick(); start_count = 1'b1; colour_in = CW'(col); s = ncyc;
      tick(); start_count = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk(name, 32'(done), 32'd1);
      tick();
   endtask

   initial begin : stim
      int s, dc;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, dc;
      tick(); tick(); tick();
      reset = 1'b0;
      chk_en = 1'b1;
      tick();
      chk("reset_x_out", 32'(x_out), 32'd0);
      chk("reset_y_out", 32'(y_out), 32'd0);
      chk("reset_colour", 32'(colour_out), 32'd0);

      // Basic box at (10,20), colour 5.
      load(10, 20);
      xs.delete(); ys.delete();
      start(5, s);
      wait_done("basic_done_timeout");
      chk("basic_count", xs.size(), 32'd16);
      chk("basic_x0", xs[0], 32'd10);
      chk("basic_y0", ys[0], 32'd20);
      chk("basic_x5", xs[5], 32'd11);
      chk("basic_y5", ys[5], 32'd21);
      chk("basic_x15", xs[15], 32'd13);
      chk("basic_y15", ys[15], 32'd23);
      chk("basic_done_after_last", done_cyc, last_plot_cyc + 1);
      chk("basic_done_cycle", done_cyc, s + 17);

      // Load and extra start during DRAW must not disturb the box.
      xs.delete(); ys.delete();
      start(2, s);
      tick(); ld_x = 1'b1; data_in = 8'd50; start_count = 1'b1;
      tick(); ld_x = 1'b0; start_count = 1'b0;
      wait_done("mid_done_timeout");
      chk("mid_count", xs.size(), 32'd16);
      chk("mid_x0", xs[0], 32'd10);
      xs.delete(); ys.delete();
      start(6, s);
      wait_done("after_done_timeout");
      chk("after_x0", xs[0], 32'd50);
      chk("after_y0", ys[0], 32'd20);

      // Reset after the 5th pixel aborts the box without done.
      xs.delete(); ys.delete();
      start(1, s);
      for (int i = 0; i < 30 && xs.size() < 5; i++) tick();
      chk("abort_reached5", xs.size(), 32'd5);
      dc = done_cnt;
      reset = 1'b1;
      #1;
      chk("abort_plot", 32'(plot), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("abort_no_done", done_cnt, dc);
      xs.delete(); ys.delete();
      start(3, s);
      wait_done("restart_done_timeout");
      chk("restart_count", xs.size(), 32'd16);

`ifdef RENDER_RECT_CLIP_EN
      load(158, 118);
      xs.delete(); ys.delete();
      start(4, s);
      wait_done("clip_done_timeout");
      chk("clip_count", xs.size(), 32'd4);
      chk("clip_x0", xs[0], 32'd158);
      chk("clip_y0", ys[0], 32'd118);
      chk("clip_x3", xs[3], 32'd159);
      chk("clip_y3", ys[3], 32'd119);
      chk("clip_done_cycle", done_cyc, s + 17);
`else
      load(254, 126);
      xs.delete(); ys.delete();
      start(4, s);
      wait_done("wrap_done_timeout");
      chk("wrap_x0", xs[0], 32'd254);
      chk("wrap_x1", xs[1], 32'd255);
      chk("wrap_x2", xs[2], 32'd0);
      chk("wrap_x3", xs[3], 32'd1);
      chk("wrap_y0", ys[0], 32'd126);
      chk("wrap_y1", ys[4], 32'd127);
      chk("wrap_y2", ys[8], 32'd0);
      chk("wrap_y3", ys[12], 32'd1);
      chk("wrap_done_cycle", done_cyc, s + 17);
`endif

      // Randomised loads and starts, checked by the model every cycle.
      for (int i = 0; i < 400; i++) begin
         tick();
         ld_x        = ($urandom_range(0, 5) == 0);
         ld_y        = ($urandom_range(0, 5) == 0);
         start_count = ($urandom_range(0, 7) == 0);
         data_in     = XW'($urandom);
         colour_in   = CW'($urandom);
      end
      tick();
      ld_x = 1'b0; ld_y = 1'b0; start_count = 1'b0;
      for (int i = 0; i < 25; i++) tick();

      // 1x1 box instance: plot at N+1, done at N+2, idle at N+3.
      tick(); start1 = 1'b1;
      tick(); start1 = 1'b0;
      chk("one_plot", 32'(plot1), 32'd1);
      chk("one_busy", 32'(busy1), 32'd1);
      chk("one_x", 32'(x1), 32'd0);
      chk("one_colour", 32'(c1), 32'd7);
      tick();
      chk("one_done", 32'(done1), 32'd1);
      chk("one_plot_off", 32'(plot1), 32'd0);
      tick();
      chk("one_busy_off", 32'(busy1), 32'd0);
      chk("one_done_off", 32'(done1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
